// File: rtl/mem_seq.sv
`default_nettype none
// ============================================================================
// mem_seq : load/store sequencer for a word-wide DRAM without byte enables.
//           Sub-word stores use a read-modify-write cycle.
// Revision: 1.0
// ============================================================================
module mem_seq #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] dram_addr,
  output logic              dram_we,
  output logic [31:0]       dram_wdata,
  input  logic [31:0]       dram_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RMW, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W+1:0]   addr_q;
  logic [2:0]          func3_q;
  logic                we_q;
  logic [31:0]         wdata_q;
  logic                rsp_err_q;
  logic [31:0]         rsp_rdata_q;

  logic                w_hs;
  logic                w_err;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_load;
  logic [31:0]         w_merge;
  logic                w_unused_bits;

  assign w_unused_bits = ^{req_addr[31:ADDR_W+2], wdata_q[31:16], we_q};

  // Reset gates the handshake so no combinational write escapes during reset.
  assign w_hs = req_valid & (state_q == S_IDLE) & rst_n;

  always_comb begin
    w_err = 1'b0;
    case (req_func3)
      3'b000, 3'b001, 3'b010: w_err = 1'b0;
      3'b100, 3'b101:         w_err = req_we;
      default:                w_err = 1'b1;
    endcase
    if (req_func3[1:0] == 2'b01 && req_addr[0])
      w_err = 1'b1;
    if (req_func3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
      w_err = 1'b1;
  end

  always_comb begin
    w_byte = dram_rdata[7:0];
    case (addr_q[1:0])
      2'd0: w_byte = dram_rdata[7:0];
      2'd1: w_byte = dram_rdata[15:8];
      2'd2: w_byte = dram_rdata[23:16];
      2'd3: w_byte = dram_rdata[31:24];
      default: w_byte = dram_rdata[7:0];
    endcase
    w_half = addr_q[1] ? dram_rdata[31:16] : dram_rdata[15:0];

    w_load = dram_rdata;
    case (func3_q)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = dram_rdata;
    endcase

    w_merge = dram_rdata;
    if (func3_q[1:0] == 2'b00) begin
      case (addr_q[1:0])
        2'd0: w_merge[7:0]   = wdata_q[7:0];
        2'd1: w_merge[15:8]  = wdata_q[7:0];
        2'd2: w_merge[23:16] = wdata_q[7:0];
        2'd3: w_merge[31:24] = wdata_q[7:0];
        default: w_merge = dram_rdata;
      endcase
    end else if (addr_q[1]) begin
      w_merge[31:16] = wdata_q[15:0];
    end else begin
      w_merge[15:0] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    dram_we    = 1'b0;
    dram_wdata = req_wdata;
    dram_addr  = addr_q[ADDR_W+1:2];
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        dram_addr = req_addr[ADDR_W+1:2];
        if (w_hs) begin
          if (w_err)
            state_d = S_RESP;
          else if (!req_we)
            state_d = S_LOAD;
          else if (req_func3[1:0] == 2'b10) begin
            state_d = S_RESP;
            dram_we = 1'b1;
          end else
            state_d = S_RMW;
        end
      end
      S_LOAD: state_d = S_RESP;
      S_RMW: begin
        state_d    = S_RESP;
        dram_we    = 1'b1;
        dram_wdata = w_merge;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      func3_q     <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (w_hs) begin
        addr_q      <= req_addr[ADDR_W+1:0];
        func3_q     <= req_func3;
        we_q        <= req_we;
        wdata_q     <= req_wdata;
        rsp_err_q   <= w_err;
        rsp_rdata_q <= '0;
      end else if (state_q == S_LOAD) begin
        rsp_rdata_q <= w_load;
      end
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
`default_nettype wire

// File: doc/mem_seq.md
MEM_SEQ -- requirements
Module: mem_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, word-address width of the data DRAM.
REQ-002 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port req_valid, input, 1, memory request from the execute stage.
REQ-005 SHALL have port req_ready, output, 1, sequencer can accept a request; high only in IDLE.
REQ-006 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-007 SHALL have port req_func3, input, 3, RISC-V funct3 (size/sign).
REQ-008 SHALL have port req_addr, input, 32, byte address.
REQ-009 SHALL have port req_wdata, input, 32, store data in the low-order bits.
REQ-010 SHALL have port rsp_valid, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata, output, 32, extended load result; 0 for stores and errors.
REQ-012 SHALL have port rsp_err, output, 1, misaligned or illegal funct3; qualified by rsp_valid.
REQ-013 SHALL have port dram_addr, output, ADDR_W, word address, equal to req_addr[ADDR_W+1:2] or the latched address.
REQ-014 SHALL have port dram_we, output, 1, word write strobe (DRAM has no byte enables).
REQ-015 SHALL have port dram_wdata, output, 32, write data.
REQ-016 SHALL have port dram_rdata, input, 32, synchronous read data, valid one cycle after dram_addr.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, RMW, RESP; transitions occur only on a handshake (req_valid & req_ready) in IDLE.
REQ-018 Legal operations SHALL be: loads funct3 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores 000 sb, 001 sh, 010 sw; every other funct3 SHALL be an error.
REQ-019 Alignment SHALL be: halfword requires addr[0]=0; word requires addr[1:0]=00; any violation SHALL be an error.
REQ-020 On handshake the sequencer SHALL latch addr, func3, we, and wdata; dram_addr SHALL come from req_addr in the handshake cycle and from the latched address afterwards.
REQ-021 Error request: IDLE->RESP; dram_we SHALL stay 0; rsp_err=1 and rsp_rdata=0 at T+1.
REQ-022 Load: IDLE->LOAD->RESP; read issued at T; at T+1 dram_rdata SHALL be lane-selected and extended, then registered; rsp_valid at T+2 with the result.
REQ-023 Lane selection SHALL be little-endian: byte = dram_rdata[8*addr[1:0]+:8]; half = dram_rdata[16*addr[1]+:16].
REQ-024 lb/lh SHALL sign-extend and lbu/lhu SHALL zero-extend to 32 bits.
REQ-025 sw: IDLE->RESP; dram_we=1 with dram_wdata=req_wdata in cycle T; rsp_valid at T+1.
REQ-026 sb/sh: IDLE->RMW->RESP; read issued at T.
REQ-027 In the RMW cycle (T+1), dram_we SHALL be 1 and dram_wdata SHALL equal dram_rdata with only the addressed byte/half replaced by wdata[7:0]/wdata[15:0]; rsp_valid at T+2.
REQ-028 dram_we SHALL be high at most one cycle per request and never in LOAD or RESP.
REQ-029 RESP SHALL always return to IDLE next cycle; req_ready=0 in LOAD, RMW, RESP, and req_valid SHALL be ignored there.
REQ-030 Back-to-back: a request presented during RESP SHALL be accepted the cycle after RESP (next IDLE); minimum issue interval is 2 cycles (sw/err), 3 cycles (load/sb/sh).
REQ-031 Upper address bits above ADDR_W+1 SHALL be ignored (wrap-around within the DRAM).
REQ-032 Outputs SHALL be registered state or decode of state plus latched fields, except dram_addr and dram_we in the handshake cycle, which are combinational from the request.

Reset
REQ-033 On rst_n low the sequencer SHALL enter IDLE immediately; rsp_valid=0, rsp_err=0, rsp_rdata=0, dram_we=0, and latched fields=0; req_ready=1 while rst_n is low.
REQ-034 Reset asserted in RMW SHALL suppress the write (dram_we drops asynchronously); the aborted request SHALL produce no response.

Verification
REQ-035 Load sign extension: mem[1]=0x80FF7F01; lb at 0x6 -> rsp_rdata=0xFFFFFFFF at T+2; lbu at 0x6 -> 0x000000FF; lh at 0x6 -> 0xFFFF80FF.
REQ-036 Store merge: mem[2]=0x11223344; sb 0xAB at 0x9 -> mem[2]=0x1122AB44; then sh 0xCDEF at 0xA -> 0xCDEFAB44; exactly one dram_we pulse each.
REQ-037 Errors: lw at 0x2, sh at 0x1, load funct3=011 -> rsp_valid at T+1 with rsp_err=1 and rsp_rdata=0; no dram_we; memory unchanged.
REQ-038 Throughput: req_valid held high with sw, sw, lw -> accepts at cycles 0, 2, 4; lw response at cycle 6; req_ready low in the gaps.
REQ-039 Reset mid-RMW: sb issued, rst_n pulsed low during RMW -> no write, memory unchanged, no rsp_valid, req_ready=1 after release.
